// File: rtl/ladybird_mem_responder.sv
// Responder end of the ladybird req/gnt/data_gnt bus: word RAM with byte strobes,
// fixed response latency and a bounded number of accepted-but-unanswered requests.
module ladybird_mem_responder #(
  parameter int XLEN            = 32,
  parameter int DEPTH_LOG2      = 10,
  parameter int READ_LATENCY    = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                req,
  output logic                gnt,
  input  logic [XLEN-1:0]     addr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [XLEN/8-1:0]   wstrb,
  output logic [XLEN-1:0]     rdata,
  output logic                data_gnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int NB    = XLEN / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("ladybird_mem_responder: READ_LATENCY must be in 1..4");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > READ_LATENCY + 1) begin : g_bad_outstanding
      $error("ladybird_mem_responder: MAX_OUTSTANDING must be in 1..READ_LATENCY+1");
    end
  endgenerate

  logic [XLEN-1:0]       mem [DEPTH];
  logic [CNT_W-1:0]      outstanding;
  logic                  accept;
  logic                  is_write;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [READ_LATENCY-1:0] vld_p;
  logic [XLEN-1:0]       dat_p [READ_LATENCY];
  logic                  unused_addr;

  // Byte offset and bits above the RAM size are dropped, so addresses wrap.
  assign word_idx    = addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^addr;
  assign is_write    = |wstrb;

  // A response retiring this cycle frees its slot for a same-cycle accept.
  assign data_gnt = vld_p[READ_LATENCY-1];
  assign gnt      = ~arst & ((outstanding < MAX_CNT) | data_gnt);
  assign accept   = req & gnt;
  assign rdata    = data_gnt ? dat_p[READ_LATENCY-1] : '0;

  always_ff @(posedge clk) begin
    if (accept && is_write) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Stage p0: RAM read on the accepting edge; later stages only shift
  always_ff @(posedge clk) begin
    if (accept) dat_p[0] <= is_write ? '0 : mem[word_idx];
    for (int s = 1; s < READ_LATENCY; s++) dat_p[s] <= dat_p[s-1];
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int s = 1; s < READ_LATENCY; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      outstanding <= '0;
    end else begin
      case ({accept, data_gnt})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_ladybird_mem_responder.sv
// Bench for ladybird_mem_responder: three latency/outstanding configurations driven
// by directed and random traffic, compared each cycle against a scheduled-response model.
module tb_ladybird_mem_responder;

  localparam int NI = 3;

  logic            clk = 1'b0;
  logic            arst;
  logic [NI-1:0]   req, gnt, data_gnt;
  logic [31:0]     addr [NI];
  logic [31:0]     wdata [NI];
  logic [31:0]     rdata [NI];
  logic [3:0]      wstrb [NI];

  always #5 clk = ~clk;

  ladybird_mem_responder #(.XLEN(32), .DEPTH_LOG2(4), .READ_LATENCY(1), .MAX_OUTSTANDING(2)) u_dut0 (
    .clk(clk), .arst(arst), .req(req[0]), .gnt(gnt[0]), .addr(addr[0]), .wdata(wdata[0]),
    .wstrb(wstrb[0]), .rdata(rdata[0]), .data_gnt(data_gnt[0]));
  ladybird_mem_responder #(.XLEN(32), .DEPTH_LOG2(4), .READ_LATENCY(3), .MAX_OUTSTANDING(2)) u_dut1 (
    .clk(clk), .arst(arst), .req(req[1]), .gnt(gnt[1]), .addr(addr[1]), .wdata(wdata[1]),
    .wstrb(wstrb[1]), .rdata(rdata[1]), .data_gnt(data_gnt[1]));
  ladybird_mem_responder #(.XLEN(32), .DEPTH_LOG2(4), .READ_LATENCY(2), .MAX_OUTSTANDING(3)) u_dut2 (
    .clk(clk), .arst(arst), .req(req[2]), .gnt(gnt[2]), .addr(addr[2]), .wdata(wdata[2]),
    .wstrb(wstrb[2]), .rdata(rdata[2]), .data_gnt(data_gnt[2]));

  // Reference model: RAM image plus a calendar of responses indexed by cycle.
  int          lat_m [NI];
  int          maxo_m [NI];
  logic [31:0] mem_m [NI][16];
  logic        sv [NI][8];
  logic [31:0] sd [NI][8];
  int          outst [NI];
  int          cyc;

  logic [NI-1:0] acc, obs_gnt, obs_dg;
  logic [31:0]   obs_rd [NI];
  logic [31:0]   last_rd [NI];
  int            checks, failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [NI-1:0] exp_dg;
    logic          eg;
    int            slot;
    logic [3:0]    idx;
    logic [31:0]   d;
    #1;
    slot = cyc % 8;
    for (int k = 0; k < NI; k++) begin
      exp_dg[k]  = sv[k][slot];
      eg         = (outst[k] < maxo_m[k]) || exp_dg[k];
      obs_gnt[k] = gnt[k];
      obs_dg[k]  = data_gnt[k];
      obs_rd[k]  = rdata[k];
      chk($sformatf("gnt%0d_c%0d", k, cyc), {31'b0, gnt[k]}, {31'b0, eg});
      chk($sformatf("data_gnt%0d_c%0d", k, cyc), {31'b0, data_gnt[k]}, {31'b0, exp_dg[k]});
      chk($sformatf("rdata%0d_c%0d", k, cyc), rdata[k], exp_dg[k] ? sd[k][slot] : 32'h0);
      if (data_gnt[k]) last_rd[k] = rdata[k];
      acc[k] = req[k] & eg;
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (exp_dg[k]) begin
        sv[k][slot] = 1'b0;
        outst[k]--;
      end
      if (acc[k]) begin
        idx = addr[k][5:2];
        if (wstrb[k] != 4'h0) begin
          for (int b = 0; b < 4; b++)
            if (wstrb[k][b]) mem_m[k][idx][8*b +: 8] = wdata[k][8*b +: 8];
          d = 32'h0;
        end else begin
          d = mem_m[k][idx];
        end
        sv[k][(cyc + lat_m[k]) % 8] = 1'b1;
        sd[k][(cyc + lat_m[k]) % 8] = d;
        outst[k]++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req[k] = 1'b1; addr[k] = a; wdata[k] = d; wstrb[k] = s;
    for (int t = 0; t < 16; t++) begin
      tick();
      if (acc[k]) begin
        req[k] = 1'b0;
        return;
      end
    end
    req[k] = 1'b0;
    chk($sformatf("send_timeout%0d", k), {31'b0, acc[k]}, 32'h1);
  endtask

  task automatic do_reset();
    arst = 1'b1;
    req  = '0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_gnt%0d", k), {31'b0, gnt[k]}, 32'h0);
      chk($sformatf("rst_data_gnt%0d", k), {31'b0, data_gnt[k]}, 32'h0);
      chk($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
      for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
      outst[k] = 0;
    end
    acc = '0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    logic [5:0] pat;
    checks = 0; failures = 0; cyc = 0;
    lat_m  = '{1, 3, 2};
    maxo_m = '{2, 2, 3};
    req = '0; acc = '0;
    for (int k = 0; k < NI; k++) begin
      addr[k] = '0; wdata[k] = '0; wstrb[k] = '0; outst[k] = 0; last_rd[k] = '0;
      for (int s = 0; s < 8; s++) begin sv[k][s] = 1'b0; sd[k][s] = '0; end
      for (int w = 0; w < 16; w++) mem_m[k][w] = '0;
    end
    arst = 1'b1;
    @(negedge clk);
    do_reset();

    // Fill every word so later reads have defined contents.
    for (int w = 0; w < 16; w++)
      for (int k = 0; k < NI; k++) send(k, 32'(w * 4), $urandom(), 4'hF);
    repeat (4) tick();

    // Single read, latency 1
    send(0, 32'h0C, 32'hDEADBEEF, 4'hF);
    send(0, 32'h0C, 32'h0, 4'h0);
    tick();
    chk("read_latency1", last_rd[0], 32'hDEADBEEF);
    chk("read_pulse", {31'b0, obs_dg[0]}, 32'h1);
    tick();

    // Byte-strobe write
    send(0, 32'h0, 32'h11223344, 4'hF);
    send(0, 32'h0, 32'hAABBCCDD, 4'b0101);
    tick();
    chk("write_ack_rdata", last_rd[0], 32'h0);
    send(0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("byte_write", last_rd[0], 32'h11BB33DD);

    // Wrap-around at 16 words
    send(0, 32'h40, 32'h5A5A5A5A, 4'hF);
    send(0, 32'h00, 32'h0, 4'h0);
    tick();
    chk("wrap", last_rd[0], 32'h5A5A5A5A);
    repeat (2) tick();

    // Throttling with latency 3, two outstanding
    req[1] = 1'b1; addr[1] = 32'h10; wdata[1] = 32'h0; wstrb[1] = 4'h0;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pat = {pat[4:0], obs_gnt[1]};
    end
    req[1] = 1'b0;
    chk("throttle_pattern", {26'b0, pat}, 32'b110110);
    repeat (5) tick();

    // Reset with two reads in flight
    send(1, 32'h14, 32'h0, 4'h0);
    send(1, 32'h18, 32'h0, 4'h0);
    do_reset();
    send(1, 32'h14, 32'h0, 4'h0);
    repeat (3) tick();
    chk("post_reset_dg", {31'b0, obs_dg[1]}, 32'h1);
    chk("post_reset_read", last_rd[1], mem_m[1][5]);
    repeat (2) tick();

    // Write then read back-to-back, latency 2
    req[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h12345678; wstrb[2] = 4'hF;
    tick();
    chk("wr_gnt", {31'b0, obs_gnt[2]}, 32'h1);
    wstrb[2] = 4'h0; wdata[2] = 32'h0;
    tick();
    chk("rd_gnt", {31'b0, obs_gnt[2]}, 32'h1);
    req[2] = 1'b0;
    tick();
    chk("wr_resp_dg", {31'b0, obs_dg[2]}, 32'h1);
    chk("wr_resp_rdata", obs_rd[2], 32'h0);
    tick();
    chk("rd_resp_dg", {31'b0, obs_dg[2]}, 32'h1);
    chk("rd_resp_rdata", obs_rd[2], 32'h12345678);
    repeat (3) tick();

    // Random traffic; requests are held stable until granted
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < NI; k++) begin
        if (!req[k] || acc[k]) begin
          req[k]   = ($urandom_range(0, 3) != 0);
          addr[k]  = $urandom();
          wdata[k] = $urandom();
          wstrb[k] = ($urandom_range(0, 1) != 0) ? 4'($urandom()) : 4'h0;
        end
      end
      tick();
      if (c == 150) do_reset();
    end
    req = '0;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ladybird_mem_responder.md
Name: ladybird_mem_responder

Overview:
- Responder (secondary) end of the ladybird req/gnt/data_gnt memory bus, the counterpart of the core's instruction and data initiator ports.
- Word-organised on-chip RAM with byte-strobe writes, a programmable fixed response latency and a bounded number of outstanding requests.
- Instantiated once per bus (instruction ROM/RAM, data RAM) in SoC and simulation tops.

Parameters:
- XLEN, 32, bus data/address width.
- DEPTH_LOG2, 10, log2 of RAM depth in words.
- READ_LATENCY, 1, cycles from request acceptance to data_gnt; legal 1..4.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests; legal 1..READ_LATENCY+1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- arst  in  1  asynchronous reset, active-high.
- req  in  1  initiator request valid.
- gnt  out  1  request accepted this cycle when req & gnt.
- addr  in  XLEN  byte address.
- wdata  in  XLEN  write data.
- wstrb  in  XLEN/8  byte write enables; all-zero = read.
- rdata  out  XLEN  response data, valid only while data_gnt = 1.
- data_gnt  out  1  one-cycle response pulse; no backpressure (initiator always ready).

Behaviour:
- Reset (arst = 1, async): gnt = 0, data_gnt = 0, rdata = 0, response pipeline valid bits and outstanding counter cleared. RAM contents are not reset. In-flight responses are discarded and never emitted after reset release.
- Addressing: word index = addr[DEPTH_LOG2+1:2]. addr[1:0] and upper bits are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2. No misalignment error.
- Accept: a request transfers on a rising edge with req & gnt. gnt is combinational: gnt = ~arst & (outstanding < MAX_OUTSTANDING | data_gnt), so a response slot retiring in the same cycle frees a slot. gnt does not depend on req.
- Write (wstrb != 0): bytes with wstrb[i] = 1 are written on the accepting edge; other bytes are unchanged. The write still produces exactly one data_gnt, with rdata = 0.
- Read (wstrb = 0): RAM is read on the accepting edge. A read accepted after a write to the same word returns the new data. A read and write cannot be simultaneous (one request per cycle).
- Response pipeline: shift register of READ_LATENCY stages carrying {valid, data}. For a request accepted at edge N, data_gnt = 1 and rdata is valid in the cycle after edge N+READ_LATENCY-1. For READ_LATENCY = 1, this is the cycle immediately following acceptance.
- Responses are strictly in order, exactly one per accepted request, and never coalesced. Back-to-back accepts produce back-to-back data_gnt pulses.
- Outstanding counter: +1 on accept, -1 on data_gnt, unchanged when both occur. Never exceeds MAX_OUTSTANDING and never underflows.
- When data_gnt = 0, rdata = 0 (no stale data on the bus).
- req with gnt = 0 has no side effects. The initiator holds addr/wdata/wstrb stable until gnt.
- Parameter violations (READ_LATENCY or MAX_OUTSTANDING out of range) are caught by an elaboration-time assertion.

Test Plan:
- Reset then single read, READ_LATENCY=1: RAM[3]=0xDEADBEEF, req with addr=0x0C accepted at edge N -> data_gnt=1, rdata=0xDEADBEEF in the cycle after N; single pulse.
- Byte write: RAM[0]=0x11223344, write addr=0x0, wdata=0xAABBCCDD, wstrb=0b0101 -> ack pulse with rdata=0; subsequent read returns 0x11BB33DD.
- Throttling, READ_LATENCY=3, MAX_OUTSTANDING=2, req held high -> gnt pattern 1,1,0,1,1,0…; data_gnt responses in order; counter never reaches 3.
- Wrap-around, DEPTH_LOG2=4: write 0x5A5A5A5A to addr 0x40 -> read of addr 0x00 returns 0x5A5A5A5A.
- Reset mid-operation: two reads in flight with READ_LATENCY=3, assert arst for 1 cycle -> gnt and data_gnt drop immediately; no data_gnt after release; next read returns correct data with normal latency.
- Write-then-read back-to-back, READ_LATENCY=2: write 0x12345678 to addr 0x20 with wstrb=0xF, then read 0x20 on the next cycle -> two consecutive data_gnt pulses, rdata 0 then 0x12345678.
